// File: rtl/mypack.sv
// Shared types and defaults for the memory responder and its backing array.
package mypack;

   localparam int unsigned DEPTH_DEF   = 1024;
   localparam int unsigned LATENCY_DEF = 2;
   localparam int unsigned ADDR_W      = 12;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BE_W        = 4;
   localparam int unsigned CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Request fields held for the duration of one transaction
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
      logic              err;
   } req_t;

   // Misaligned or beyond the last word of the array
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                     input int unsigned depth);
      return (addr[1:0] != 2'b00) || (32'(addr[ADDR_W-1:2]) >= depth);
   endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word array with byte write enables and one-cycle synchronous read.
module mem_array_sp
   import mypack::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents and read register are deliberately left out of reset
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Request/response front end over a single-port array: optional wait cycles,
// one access cycle, then a response held until the initiator takes it.
module mem_responder
   import mypack::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned LATENCY = LATENCY_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              req_ready_d;
   logic              rsp_valid_d;
   logic              rsp_err_d;
   logic              rd_ok, rd_ok_d;
   logic              handshake;
   logic              mem_en;
   logic [DATA_W-1:0] mem_rdata;
   req_t              req_q;
   logic [AW-1:0]     widx_q;

   assign handshake = req_valid && req_ready;

   // Next state and next registered outputs
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      req_ready_d = 1'b0;
      rsp_valid_d = rsp_valid;
      rsp_err_d   = rsp_err;
      rd_ok_d     = rd_ok;
      case (state)
         IDLE: begin
            if (handshake) begin
               if (LATENCY > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         ACCESS: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_q.err;
            rd_ok_d     = !req_q.err && !req_q.we;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rd_ok_d     = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rd_ok     <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rd_ok     <= rd_ok_d;
      end
   end

   // Request capture; datapath only, no reset needed
   always_ff @(posedge clk) begin
      if (handshake) begin
         req_q.we    <= req_we;
         req_q.wdata <= req_wdata;
         req_q.be    <= req_be;
         req_q.err   <= addr_err(req_addr, DEPTH);
         widx_q      <= AW'(req_addr[ADDR_W-1:2]);
      end
   end

   // rst gating keeps an aborted request from touching the array
   assign mem_en = (state == ACCESS) && !req_q.err && !rst;

   mem_array_sp #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .en    (mem_en),
      .we    (req_q.we),
      .be    (req_q.be),
      .addr  (widx_q),
      .wdata (req_q.wdata),
      .rdata (mem_rdata)
   );

   // Read register is untouched while in RESP, so data is stable under backpressure
   assign rsp_rdata = rd_ok ? mem_rdata : '0;

endmodule
